fetch_unit: RTL and testbench

//   Parametrised instruction-fetch front end. Holds the fetch PC, issues in-order

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 101 ++++++++++
 rtl/fetch_unit.sv | 196 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch front end: default address
//   and instruction widths, the default reset PC, the PC increment between
//   sequential fetches and the {pc, inst} entry layout handed to the decoder.
//   No ports; imported by fetch_unit and fetch_fifo.
// ---------------------------------------------------------------------------
package fetch_pkg;

    // Default widths used when the top level is not overridden
    localparam int XLEN_DEF     = 32;
    localparam int ILEN_DEF     = 32;
    localparam int FQ_DEPTH_DEF = 2;

    // First fetch address after reset
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    // Sequential fetches advance by one 32-bit instruction
    localparam int PC_STEP = 4;

    // One decoded-side queue entry at the default widths; the queue stores
    // exactly this layout with pc in the upper bits and inst in the lower bits
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO with a single-cycle flush. Used twice by the fetch
//   unit: once to remember the PC of every request still waiting for its
//   response, and once as the instruction queue feeding the decoder.
//   Push while full is accepted only when a pop happens in the same cycle;
//   pop while empty is ignored. Flush wins over push and pop.
//
// Parameters
//   DEPTH    number of entries (power of 2, >= 1)
//   WIDTH    entry width in bits
//
// Ports
//   clk      in   1                       clock
//   rst_n    in   1                       asynchronous reset, active low
//   flush_i  in   1                       discard every entry this cycle
//   push_i   in   1                       write wdata_i at the tail
//   wdata_i  in   WIDTH                   data to write
//   pop_i    in   1                       remove the head entry
//   rdata_o  out  WIDTH                   head entry (combinational)
//   count_o  out  $clog2(DEPTH+1)         number of valid entries
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEF,
    parameter int WIDTH = XLEN_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rdPtr_q;
    logic [AW-1:0]    wrPtr_q;
    logic [CW-1:0]    count_q;

    logic isEmpty;
    logic isFull;
    logic doPop;
    logic doPush;

    // Pointers wrap explicitly at DEPTH-1 so a single-entry FIFO stays at 0
    function automatic logic [AW-1:0] ptrInc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A push into a full FIFO is only taken when the head leaves in the same
    // cycle, which keeps the occupancy unchanged
    always_comb begin
        isEmpty = (count_q == '0);
        isFull  = (count_q == CW'(DEPTH));
        doPop   = pop_i & ~isEmpty;
        doPush  = push_i & (~isFull | doPop);
    end

    // Storage has no reset: an entry is only ever read after being written
    always_ff @(posedge clk) begin
        if (doPush && !flush_i) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush simply empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= ptrInc(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_q <= ptrInc(rdPtr_q);
            end
            if (doPush && !doPop) begin
                count_q <= count_q + CW'(1);
            end else if (doPop && !doPush) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end. Holds the fetch PC, issues in-order
//   valid/ready requests to instruction memory, keeps several fetches in
//   flight, buffers responses in a small queue and hands {pc, inst} to the
//   decoder. A redirect (jump/trap) flushes everything and restarts fetch at
//   the new PC; responses still in flight for the old path are counted and
//   discarded when they arrive.
//
// Optional feature
//   IFU_PERF_CNT_EN  when defined, adds perf_fetch_cnt/perf_drop_cnt ports and
//                    the 32-bit wrapping counters behind them.
//
// Parameters
//   XLEN      address/PC width
//   ILEN      instruction width
//   RESET_PC  first fetch address after reset
//   FQ_DEPTH  in-flight + buffered fetch limit (power of 2, >= 1)
//
// Ports
//   clk             in   1     clock
//   rst_n           in   1     asynchronous reset, active low
//   req_valid       out  1     fetch request valid
//   req_ready       in   1     memory accepts request
//   req_addr        out  XLEN  fetch address
//   rsp_valid       in   1     response valid, in order, no back-pressure
//   rsp_data        in   ILEN  fetched instruction
//   inst_valid      out  1     queue head valid to decoder
//   inst_ready      in   1     decoder consumes head
//   inst            out  ILEN  head instruction
//   inst_pc         out  XLEN  head PC
//   redirect_valid  in   1     flush and restart fetch
//   redirect_pc     in   XLEN  new fetch PC
//   perf_fetch_cnt  out  32    responses enqueued     (IFU_PERF_CNT_EN only)
//   perf_drop_cnt   out  32    responses discarded    (IFU_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ILEN     = ILEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              FQ_DEPTH = FQ_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [ILEN-1:0] rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_drop_cnt
`endif
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int SW = CW + 2;
    localparam int EW = XLEN + ILEN;

    logic [XLEN-1:0] fetchPc_q;
    logic [XLEN-1:0] fetchPc_d;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   drop_d;

    logic [CW-1:0]   pcCount;
    logic [XLEN-1:0] pcHead;
    logic [CW-1:0]   qCount;
    logic [EW-1:0]   qHead;

    logic [SW-1:0]   creditUsed;
    logic            reqFire;
    logic            rspAccept;
    logic            rspDiscard;
    logic            instFire;

    // Every slot is accounted for once: requests waiting for a response (the
    // PC FIFO occupancy), entries buffered for the decoder, and old-path
    // responses still to be thrown away. A new request is only issued while
    // that total leaves room, so the queue can never overflow. Holding
    // req_valid low during reset keeps memory idle before the first fetch.
    always_comb begin
        creditUsed = SW'(pcCount) + SW'(qCount) + SW'(drop_q);
        req_valid  = rst_n & ~redirect_valid & (creditUsed < SW'(FQ_DEPTH));
        req_addr   = fetchPc_q;
        reqFire    = req_valid & req_ready;
    end

    // Responses arrive in order, so while old-path responses are pending the
    // next one must be one of them. A redirect discards whatever arrives in
    // the same cycle, and also cancels a decoder handshake in that cycle.
    always_comb begin
        rspDiscard = rsp_valid & (redirect_valid | (drop_q != '0));
        rspAccept  = rsp_valid & ~redirect_valid & (drop_q == '0);
        inst_valid = (qCount != '0);
        instFire   = inst_valid & inst_ready & ~redirect_valid;
        inst_pc    = qHead[EW-1:ILEN];
        inst       = qHead[ILEN-1:0];
    end

    // On redirect all in-flight requests become drops; the response in this
    // same cycle (if any) retires one of them, whether it came from the old
    // drop backlog or from the outstanding set
    always_comb begin
        fetchPc_d = fetchPc_q;
        drop_d    = drop_q;
        if (redirect_valid) begin
            fetchPc_d = redirect_pc;
            drop_d    = drop_q + pcCount - CW'(rsp_valid);
        end else begin
            if (reqFire) begin
                fetchPc_d = fetchPc_q + XLEN'(PC_STEP);
            end
            if (rspDiscard) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    // Fetch PC and drop backlog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc_q <= RESET_PC;
            drop_q    <= '0;
        end else begin
            fetchPc_q <= fetchPc_d;
            drop_q    <= drop_d;
        end
    end

    // PC of each request in flight, written when memory accepts the request
    // and read back when its response is enqueued; its occupancy is the
    // outstanding-request count, and a flush moves those requests to drop
    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (XLEN)
    ) u_pc_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (reqFire),
        .wdata_i (fetchPc_q),
        .pop_i   (rspAccept),
        .rdata_o (pcHead),
        .count_o (pcCount)
    );

    // Instruction queue of {pc, inst} entries presented to the decoder
    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (EW)
    ) u_inst_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (rspAccept),
        .wdata_i ({pcHead, rsp_data}),
        .pop_i   (instFire),
        .rdata_o (qHead),
        .count_o (qCount)
    );

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perfFetchCnt_q;
    logic [31:0] perfDropCnt_q;

    // Free-running event counters; they wrap silently at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfFetchCnt_q <= '0;
            perfDropCnt_q  <= '0;
        end else begin
            if (rspAccept) begin
                perfFetchCnt_q <= perfFetchCnt_q + 32'd1;
            end
            if (rspDiscard) begin
                perfDropCnt_q <= perfDropCnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perfFetchCnt_q;
    assign perf_drop_cnt  = perfDropCnt_q;
`else
    // Performance counters not built
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit with a 1-cycle (stallable) instruction memory model.
//   Expected {pc, inst} pairs are queued when memory accepts a request and
//   compared when the decoder handshake takes the head. A per-cycle table
//   covers start-up fetch order and a held request; hand-written sequences
//   cover queue fill, redirects and reset in mid-stream.
//   Define IFU_PERF_CNT_EN to build and check the performance counters.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          ILEN     = 32;
    localparam int          FQ_DEPTH = 2;
    localparam logic [31:0] RST_PC   = 32'h8000_0000;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [ILEN-1:0] rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]     perf_fetch_cnt;
    logic [31:0]     perf_drop_cnt;
`endif

    fetch_unit #(
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .RESET_PC (RST_PC),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state and memory model
    logic [63:0] expQ[$];
    logic [31:0] memQ[$];
    int          stale;
    int          expFetch;
    int          expDrop;
    bit          rspEn;

    int compared;
    int mismatched;

    typedef struct {
        bit          reqReady;
        bit          instReady;
        bit          expReqValid;
        logic [31:0] expReqAddr;
        bit          expInstValid;
        logic [31:0] expInstPc;
    } vec_t;

    vec_t vecs[13];

    // Instruction word returned by memory for a given address
    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit reqReady, input bit instReady);
        req_ready  = reqReady;
        inst_ready = instReady;
    endtask

    // One clock: record handshakes at the falling edge, then after the rising
    // edge present the next memory response (if memory is enabled)
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        if (rst_n) begin
            if (redirect_valid) begin
                stale += memQ.size();
                expQ.delete();
            end else if (inst_valid && inst_ready) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_inst: actual pc %h required no instruction", inst_pc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("inst_pc", {32'h0, inst_pc}, {32'h0, e[63:32]});
                    checkOutput("inst", {32'h0, inst}, {32'h0, e[31:0]});
                end
            end
            if (rsp_valid) begin
                void'(memQ.pop_front());
                if (stale > 0) begin
                    stale--;
                    expDrop++;
                end else begin
                    expFetch++;
                end
            end
            if (req_valid && req_ready) begin
                expQ.push_back({req_addr, memData(req_addr)});
                memQ.push_back(req_addr);
            end
        end
        @(posedge clk);
        #1;
        if (rspEn && memQ.size() > 0) begin
            rsp_valid = 1'b1;
            rsp_data  = memData(memQ[0]);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
    endtask

    task automatic checkCounters(input string tag);
`ifdef IFU_PERF_CNT_EN
        checkOutput({tag, "_perf_fetch"}, {32'h0, perf_fetch_cnt}, 64'(expFetch));
        checkOutput({tag, "_perf_drop"}, {32'h0, perf_drop_cnt}, 64'(expDrop));
`else
        $display("[TB] %s: performance counters not built", tag);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        compared   = 0;
        mismatched = 0;
        stale      = 0;
        expFetch   = 0;
        expDrop    = 0;
        rspEn      = 1'b1;

        // Cycle table after reset release: 1-cycle memory, decoder always ready,
        // memory stalls requests in rows 6..10
        vecs[0]  = '{1, 1, 1, 32'h8000_0000, 0, 32'h0};
        vecs[1]  = '{1, 1, 1, 32'h8000_0004, 0, 32'h0};
        vecs[2]  = '{1, 1, 0, 32'h0,         1, 32'h8000_0000};
        vecs[3]  = '{1, 1, 1, 32'h8000_0008, 1, 32'h8000_0004};
        vecs[4]  = '{1, 1, 1, 32'h8000_000C, 0, 32'h0};
        vecs[5]  = '{1, 1, 0, 32'h0,         1, 32'h8000_0008};
        vecs[6]  = '{0, 1, 1, 32'h8000_0010, 1, 32'h8000_000C};
        vecs[7]  = '{0, 1, 1, 32'h8000_0010, 0, 32'h0};
        vecs[8]  = '{0, 1, 1, 32'h8000_0010, 0, 32'h0};
        vecs[9]  = '{0, 1, 1, 32'h8000_0010, 0, 32'h0};
        vecs[10] = '{0, 1, 1, 32'h8000_0010, 0, 32'h0};
        vecs[11] = '{1, 1, 1, 32'h8000_0010, 0, 32'h0};
        vecs[12] = '{1, 1, 1, 32'h8000_0014, 0, 32'h0};

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        applyStimulus(1'b1, 1'b1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_valid", 64'(req_valid), 64'd0);
        checkOutput("reset_inst_valid", 64'(inst_valid), 64'd0);
        checkCounters("reset");
        rst_n = 1'b1;

        // Start-up fetch order and a request held for five cycles
        $display("[TB] table: start-up and held request");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].reqReady, vecs[i].instReady);
            #1;
            checkOutput($sformatf("row%0d_req_valid", i), 64'(req_valid), 64'(vecs[i].expReqValid));
            if (vecs[i].expReqValid) begin
                checkOutput($sformatf("row%0d_req_addr", i), {32'h0, req_addr}, {32'h0, vecs[i].expReqAddr});
            end
            checkOutput($sformatf("row%0d_inst_valid", i), 64'(inst_valid), 64'(vecs[i].expInstValid));
            if (vecs[i].expInstValid) begin
                checkOutput($sformatf("row%0d_inst_pc", i), {32'h0, inst_pc}, {32'h0, vecs[i].expInstPc});
            end
            tick();
        end

        // Decoder stalls: queue fills, requests stop; then drains in order
        $display("[TB] sequence: queue fill");
        applyStimulus(1'b1, 1'b0);
        repeat (8) tick();
        #1;
        checkOutput("full_req_valid", 64'(req_valid), 64'd0);
        checkOutput("full_inst_valid", 64'(inst_valid), 64'd1);
        checkOutput("full_head_pc", {32'h0, inst_pc}, {32'h0, 32'h8000_0010});
        applyStimulus(1'b1, 1'b1);
        repeat (10) tick();

        // Redirect with two requests outstanding
        $display("[TB] sequence: redirect with outstanding requests");
        applyStimulus(1'b0, 1'b1);
        repeat (4) tick();
        rspEn = 1'b0;
        applyStimulus(1'b1, 1'b1);
        repeat (3) tick();
        #1;
        checkOutput("two_out_req_valid", 64'(req_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        #1;
        checkOutput("redirect_blocks_req", 64'(req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        checkOutput("redirect_req_addr", {32'h0, req_addr}, {32'h0, 32'h8000_0100});
        rspEn = 1'b1;
        for (int i = 0; i < 20 && !inst_valid; i++) tick();
        #1;
        checkOutput("redirect_inst_valid", 64'(inst_valid), 64'd1);
        checkOutput("redirect_inst_pc", {32'h0, inst_pc}, {32'h0, 32'h8000_0100});
        repeat (6) tick();

        // Redirect in the same cycle as a response and a decoder handshake
        $display("[TB] sequence: redirect coinciding with response and handshake");
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            #1;
            if (rsp_valid && inst_valid) found = 1'b1;
        end
        checkOutput("coincide_found", 64'(found), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        #1;
        checkOutput("coincide_inst_valid", 64'(inst_valid), 64'd0);
        checkOutput("coincide_req_valid", 64'(req_valid), 64'd1);
        checkOutput("coincide_req_addr", {32'h0, req_addr}, {32'h0, 32'h8000_0200});
        for (int i = 0; i < 20 && !inst_valid; i++) tick();
        #1;
        checkOutput("coincide_next_valid", 64'(inst_valid), 64'd1);
        checkOutput("coincide_next_pc", {32'h0, inst_pc}, {32'h0, 32'h8000_0200});
        repeat (5) tick();

        // Reset in mid-stream
        $display("[TB] sequence: reset mid-stream");
        applyStimulus(1'b1, 1'b0);
        repeat (3) tick();
        checkCounters("pre_reset");
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_req_valid", 64'(req_valid), 64'd0);
        checkOutput("midreset_inst_valid", 64'(inst_valid), 64'd0);
        expQ.delete();
        memQ.delete();
        stale     = 0;
        expFetch  = 0;
        expDrop   = 0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        checkCounters("midreset");
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1);
        #1;
        checkOutput("restart_req_valid", 64'(req_valid), 64'd1);
        checkOutput("restart_req_addr", {32'h0, req_addr}, {32'h0, RST_PC});
        repeat (12) tick();
        checkCounters("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
